scroll_display_ctrl: RTL and testbench
======================================

SCROLL_DISPLAY_CTRL -- requirements
Module: scroll_display_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4, SHALL set the number of multiplexed 7-segment digits (range 1..8).
REQ-002 Parameter MSG_LEN, default 16, SHALL set the number of 4-bit message entries (range 2..256).
REQ-003 Parameter DEBOUNCE, default 2000, SHALL set the number of cycles an input must hold stable before its debounced level changes.
REQ-004 Parameter REFRESH_DIV, default 1000, SHALL set the number of cycles per digit slot.
REQ-005 Parameter AUTO_PERIOD, default 50000000, SHALL set the number of cycles per auto-scroll step.
REQ-006 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-008 btn_next  input  1  SHALL be the raw, asynchronous, bouncing button that steps the message forward.
REQ-009 btn_prev  input  1  SHALL be the raw, asynchronous, bouncing button that steps the message backward.
REQ-010 auto_en  input  1  SHALL be an asynchronous level that enables auto-scroll when high.
REQ-011 an  output  N_DIGITS  SHALL drive the active-low digit anodes; an[N_DIGITS-1] is the leftmost digit.
REQ-012 seg  output  8  SHALL drive the active-low segments {a,b,c,d,e,f,g,dp}, with a as the MSB.
REQ-013 pointer  output  clog2(MSG_LEN)  SHALL carry the committed message start index.

Function
REQ-014 btn_next, btn_prev and auto_en SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 Each button debouncer SHALL change its debounced level only after the synchronized input has differed from that level for DEBOUNCE consecutive cycles; any glitch SHALL restart the count.
REQ-016 A 0->1 edge of a debounced level SHALL generate a one-cycle step pulse; a held button SHALL produce exactly one step, with no auto-repeat.
REQ-017 A next pulse SHALL set pointer to (pointer+1) mod MSG_LEN; a prev pulse SHALL set it to (pointer-1) mod MSG_LEN, wrapping MSG_LEN-1->0 and 0->MSG_LEN-1.
REQ-018 Simultaneous next and prev pulses SHALL leave pointer unchanged.
REQ-019 While synchronized auto_en is high, an auto timer SHALL count 0..AUTO_PERIOD-1; at the terminal count it SHALL advance pointer by +1 mod MSG_LEN and restart.
REQ-020 While auto_en is low, the auto timer SHALL be held at 0.
REQ-021 A manual pulse SHALL reset the auto timer to 0; when a manual pulse and an auto tick coincide, the manual action SHALL win and the auto tick SHALL be dropped.
REQ-022 Message storage SHALL hold MSG_LEN 4-bit entries, with entry i loaded to i mod 16 on reset.
REQ-023 A refresh counter SHALL count 0..REFRESH_DIV-1; on wrap, the slot index SHALL advance 0..N_DIGITS-1 and then wrap to 0.
REQ-024 frame_ptr SHALL latch pointer only when the slot index wraps to 0, so a frame never mixes two pointer values.
REQ-025 Slot k SHALL assert an[N_DIGITS-1-k] low and show entry (frame_ptr+k) mod MSG_LEN.
REQ-026 During refresh count 0 of every slot, all anodes SHALL be high (ghost blanking).
REQ-027 The hex decoder SHALL map 0-F to standard patterns, with dp always off (1).
REQ-028 Example decodes: 0 SHALL give seg=8'b00000011; 1 SHALL give seg=8'b10011111; F SHALL give seg=8'b01110001.
REQ-029 an and seg SHALL be registered outputs, with one cycle of latency from the slot/refresh state.

Reset
REQ-030 While reset is high at a clock edge, the block SHALL set pointer, frame_ptr, slot index, refresh counter, auto timer and debounce counters to 0.
REQ-031 While reset is high at a clock edge, the block SHALL clear debounced levels and synchronizers to 0.
REQ-032 While reset is high at a clock edge, the block SHALL set an to all 1s and seg to 8'hFF.
REQ-033 Reset asserted mid-debounce or mid-frame SHALL discard all pending presses and ticks, and no step SHALL occur on release.
REQ-034 Release of reset SHALL resume operation on the next edge, starting from slot 0 and refresh count 0.

Verification (N_DIGITS=4, MSG_LEN=16, DEBOUNCE=4, REFRESH_DIV=4, AUTO_PERIOD=20)
REQ-035 Hold btn_next high 3 cycles, low, then high 3 cycles -> pointer stays 0.
REQ-036 Hold btn_next high 10 cycles -> pointer becomes 1 exactly once, at cycle 2+4+1 after assertion.
REQ-037 Pulse btn_prev once from reset -> pointer=15; next frame shows digits F,0,1,2 left to right; slot 0 seg=8'b01110001.
REQ-038 Debounced next and prev pulses in the same cycle -> pointer unchanged.
REQ-039 auto_en=1 for 65 cycles after sync -> pointer=3.
REQ-040 A manual next pulse coincident with an auto tick -> pointer advances by exactly 1 and the auto timer restarts at 0.
REQ-041 Assert reset mid-frame while btn_next is bouncing -> next cycle an=4'b1111, seg=8'hFF, pointer=0, and no step after release.

Source files
------------

// File: rtl/scroll_display_ctrl.sv
// Scrolling 7-segment message display controller.
// Two debounced buttons step a message start pointer forward/backward, an
// optional auto-scroll timer advances it periodically, and a multiplexed
// refresh engine shows N_DIGITS consecutive message entries per frame.
module scroll_display_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int MSG_LEN     = 16,
    parameter int DEBOUNCE    = 2000,
    parameter int REFRESH_DIV = 1000,
    parameter int AUTO_PERIOD = 50000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       btn_next,
    input  logic                       btn_prev,
    input  logic                       auto_en,
    output logic [N_DIGITS-1:0]        an,
    output logic [7:0]                 seg,
    output logic [$clog2(MSG_LEN)-1:0] pointer
);

    localparam int PW = $clog2(MSG_LEN);
    localparam int DW = (DEBOUNCE > 1)    ? $clog2(DEBOUNCE)    : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam int SW = (N_DIGITS > 1)    ? $clog2(N_DIGITS)    : 1;

    // bit 0: next button, bit 1: prev button, bit 2: auto enable
    logic [2:0]          raw_in;
    logic [2:0]          sync1;
    logic [2:0]          sync2;

    logic [1:0]          db_level;
    logic [1:0]          db_level_d;
    logic [DW-1:0]       db_cnt [2];

    logic                step_next;
    logic                step_prev;
    logic                manual;
    logic                auto_on;
    logic                auto_tick;
    logic [AW-1:0]       auto_cnt;

    logic [PW-1:0]       ptr_inc;
    logic [PW-1:0]       ptr_dec;

    logic [3:0]          msg [MSG_LEN];

    logic [RW-1:0]       refresh_cnt;
    logic [SW-1:0]       slot;
    logic [PW-1:0]       frame_ptr;

    logic [PW-1:0]       disp_idx;
    logic [3:0]          digit;
    logic [N_DIGITS-1:0] an_next;

    // Active-low {a,b,c,d,e,f,g,dp}; decimal point is never lit.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0:    s = 8'b0000_0011;
            4'h1:    s = 8'b1001_1111;
            4'h2:    s = 8'b0010_0101;
            4'h3:    s = 8'b0000_1101;
            4'h4:    s = 8'b1001_1001;
            4'h5:    s = 8'b0100_1001;
            4'h6:    s = 8'b0100_0001;
            4'h7:    s = 8'b0001_1111;
            4'h8:    s = 8'b0000_0001;
            4'h9:    s = 8'b0000_1001;
            4'hA:    s = 8'b0001_0001;
            4'hB:    s = 8'b1100_0001;
            4'hC:    s = 8'b0110_0011;
            4'hD:    s = 8'b1000_0101;
            4'hE:    s = 8'b0110_0001;
            default: s = 8'b0111_0001;
        endcase
        return s;
    endfunction

    assign raw_in = {auto_en, btn_prev, btn_next};

    // Two-flop synchronizers for every asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // Debouncers: level follows the input only after DEBOUNCE consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_level   <= '0;
            db_level_d <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_level_d <= db_level;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Rising edge of a debounced level gives exactly one step per press.
    assign step_next = db_level[0] & ~db_level_d[0];
    assign step_prev = db_level[1] & ~db_level_d[1];
    assign manual    = step_next | step_prev;
    assign auto_on   = sync2[2];
    assign auto_tick = auto_on && (auto_cnt == AW'(AUTO_PERIOD - 1));

    // Auto-scroll timer; any manual step restarts the period.
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_cnt <= '0;
        end else if (!auto_on || manual || auto_tick) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AW'(1);
        end
    end

    assign ptr_inc = (pointer == PW'(MSG_LEN - 1)) ? '0 : pointer + PW'(1);
    assign ptr_dec = (pointer == '0) ? PW'(MSG_LEN - 1) : pointer - PW'(1);

    // Pointer update: manual steps take priority and swallow a coincident auto tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            pointer <= '0;
        end else if (step_next && !step_prev) begin
            pointer <= ptr_inc;
        end else if (step_prev && !step_next) begin
            pointer <= ptr_dec;
        end else if (!manual && auto_tick) begin
            pointer <= ptr_inc;
        end
    end

    // Message storage, loaded with a counting pattern on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg[i] <= 4'(i % 16);
            end
        end
    end

    // Refresh timing: slot advances on each refresh wrap; frame_ptr only latches at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            slot        <= '0;
            frame_ptr   <= '0;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            if (slot == SW'(N_DIGITS - 1)) begin
                slot      <= '0;
                frame_ptr <= pointer;
            end else begin
                slot <= slot + SW'(1);
            end
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // Select the entry for the current slot and its anode; blank on the first refresh count.
    always_comb begin
        disp_idx = PW'((int'(frame_ptr) + int'(slot)) % MSG_LEN);
        digit    = msg[disp_idx];
        an_next  = '1;
        if (refresh_cnt != '0) begin
            an_next[N_DIGITS - 1 - int'(slot)] = 1'b0;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= '1;
            seg <= 8'hFF;
        end else begin
            an  <= an_next;
            seg <= hex_to_seg(digit);
        end
    end

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Directed self-checking bench for scroll_display_ctrl with short timing parameters.
module tb_scroll_display_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic [3:0] an;
    logic [7:0] seg;
    logic [3:0] pointer;

    int checks = 0;
    int errors = 0;

    scroll_display_ctrl #(
        .N_DIGITS    (4),
        .MSG_LEN     (16),
        .DEBOUNCE    (4),
        .REFRESH_DIV (4),
        .AUTO_PERIOD (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .auto_en  (auto_en),
        .an       (an),
        .seg      (seg),
        .pointer  (pointer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        auto_en  = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] prev_an;
        logic       found;

        // Reset state and restart from slot 0 / refresh 0
        reset    = 1'b1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        auto_en  = 1'b0;
        tick(2);
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, 8'hFF);
        check("reset_ptr", pointer, 4'h0);
        reset = 1'b0;
        tick(1);
        check("release_blank", an, 4'hF);
        tick(1);
        check("release_slot0_an", an, 4'b0111);
        check("release_slot0_seg", seg, 8'b0000_0011);

        // Short bursts never reach the debounce threshold
        btn_next = 1'b1; tick(3);
        btn_next = 1'b0; tick(1);
        btn_next = 1'b1; tick(3);
        btn_next = 1'b0; tick(12);
        check("glitch_ptr", pointer, 4'h0);

        // Held press: single step exactly 7 edges after assertion
        btn_next = 1'b1;
        tick(6);
        check("press_early", pointer, 4'h0);
        tick(1);
        check("press_step", pointer, 4'h1);
        tick(3);
        btn_next = 1'b0;
        tick(20);
        check("press_no_repeat", pointer, 4'h1);

        // Prev from 0 wraps to 15; next frame shows F,0,1,2
        do_reset();
        btn_prev = 1'b1; tick(10);
        btn_prev = 1'b0; tick(10);
        check("prev_wrap", pointer, 4'hF);
        tick(40);
        found   = 1'b0;
        prev_an = an;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (an == 4'b0111 && prev_an != 4'b0111) found = 1'b1;
            prev_an = an;
        end
        check("frame_found", found, 1'b1);
        check("slot0_seg", seg, 8'b0111_0001);
        tick(3);
        check("ghost_blank", an, 4'hF);
        tick(1);
        check("slot1_an", an, 4'b1011);
        check("slot1_seg", seg, 8'b0000_0011);
        tick(4);
        check("slot2_an", an, 4'b1101);
        check("slot2_seg", seg, 8'b1001_1111);
        tick(4);
        check("slot3_an", an, 4'b1110);
        check("slot3_seg", seg, 8'b0010_0101);

        // Simultaneous next+prev leaves pointer; then next wraps 15 -> 0
        btn_next = 1'b1; btn_prev = 1'b1; tick(10);
        btn_next = 1'b0; btn_prev = 1'b0; tick(20);
        check("both_ptr", pointer, 4'hF);
        btn_next = 1'b1; tick(10);
        btn_next = 1'b0; tick(10);
        check("next_wrap", pointer, 4'h0);

        // Auto-scroll: ticks at edges 22, 42, 62 after auto_en rises
        do_reset();
        auto_en = 1'b1;
        tick(21);
        check("auto_before_tick", pointer, 4'h0);
        tick(1);
        check("auto_tick1", pointer, 4'h1);
        tick(39);
        check("auto_before_tick3", pointer, 4'h2);
        tick(1);
        check("auto_tick3", pointer, 4'h3);
        tick(5);
        check("auto_65", pointer, 4'h3);
        auto_en = 1'b0;
        tick(30);
        check("auto_held", pointer, 4'h3);

        // Manual step coincident with auto tick: only +1, next tick 20 later
        do_reset();
        auto_en = 1'b1;
        tick(15);
        btn_next = 1'b1;
        tick(6);
        check("coinc_before", pointer, 4'h0);
        tick(1);
        check("coinc_step", pointer, 4'h1);
        btn_next = 1'b0;
        tick(19);
        check("coinc_restart_hold", pointer, 4'h1);
        tick(1);
        check("coinc_next_tick", pointer, 4'h2);
        auto_en = 1'b0;
        tick(5);

        // Manual step mid-period restarts the auto timer
        do_reset();
        auto_en = 1'b1;
        tick(5);
        btn_next = 1'b1;
        tick(7);
        check("restart_step", pointer, 4'h1);
        btn_next = 1'b0;
        tick(19);
        check("restart_no_early_tick", pointer, 4'h1);
        tick(1);
        check("restart_tick", pointer, 4'h2);
        auto_en = 1'b0;
        tick(5);

        // Reset during a bouncing press discards it
        btn_next = 1'b1; tick(2);
        btn_next = 1'b0; tick(1);
        btn_next = 1'b1; tick(1);
        btn_next = 1'b0; tick(1);
        btn_next = 1'b1; tick(4);
        reset    = 1'b1;
        btn_next = 1'b0;
        tick(1);
        check("midreset_an", an, 4'hF);
        check("midreset_seg", seg, 8'hFF);
        check("midreset_ptr", pointer, 4'h0);
        tick(1);
        reset = 1'b0;
        tick(20);
        check("midreset_no_step", pointer, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
